// File: rtl/prng_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the PRNG arbiter.
package prng_pkg;

  localparam int unsigned LFSR_WIDTH = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEED  = 2'd2
  } state_t;

  // x^4 + x^3 + 1, maximal length (15), never reaches zero from a non-zero state
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/prng_lfsr.sv
// 4-bit Fibonacci LFSR register with seed load; a zero seed is replaced by SEED.
module prng_lfsr
  import prng_pkg::*;
#(
  parameter int unsigned       WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing one fresh LFSR sample per grant, with reseed sequencing.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned       NREQ  = 4,
  parameter int unsigned       WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rand_data,
  output logic             rand_valid,
  output logic             busy
);

  localparam int unsigned      PTR_W   = $clog2(NREQ);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   win_onehot;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    cand;
  logic              win_found;
  logic              lfsr_load;
  logic              lfsr_step;

  // The current winner's req is still high for one cycle; mask it out.
  assign eligible = req & ~gnt;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = ptr;
    cand       = '0;
    win_onehot = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!win_found && eligible[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

  // IDLE and GRANT share one transition rule; SEED differs only by ignoring seed_load.
  always_comb begin
    state_nxt = ST_IDLE;
    gnt_nxt   = '0;
    ptr_nxt   = ptr;
    lfsr_load = 1'b0;
    if (seed_load && (state != ST_SEED)) begin
      state_nxt = ST_SEED;
      lfsr_load = 1'b1;
    end else if (win_found) begin
      state_nxt = ST_GRANT;
      gnt_nxt   = win_onehot;
      ptr_nxt   = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= PTR_RST;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign lfsr_step  = (state == ST_GRANT);
  assign rand_valid = |gnt;
  assign busy       = (state != ST_IDLE);

  // A load on the closing edge of a grant supersedes that grant's step.
  prng_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_val),
    .step     (lfsr_step),
    .q        (rand_data)
  );

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed self-checking bench for prng_arbiter with hand-computed expectations.
module tb_prng_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [3:0] seed_val;
  logic [3:0] gnt;
  logic [3:0] rand_data;
  logic       rand_valid;
  logic       busy;

  int unsigned errors;
  int unsigned checks;

  logic [3:0]  seq_exp [16];
  logic [3:0]  rr_gnt  [5];
  logic [3:0]  rr_dat  [5];
  logic [15:0] seen;

  prng_arbiter #(
    .NREQ  (4),
    .WIDTH (4),
    .SEED  (4'b1001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .gnt        (gnt),
    .rand_data  (rand_data),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [3:0] d);
    chk({tag, "_gnt"},   16'(gnt), 16'(g));
    chk({tag, "_valid"}, 16'(rand_valid), 16'd1);
    chk({tag, "_busy"},  16'(busy), 16'd1);
    chk({tag, "_data"},  16'(rand_data), 16'(d));
  endtask

  task automatic chk_quiet(input string tag, input logic b);
    chk({tag, "_gnt"},   16'(gnt), 16'd0);
    chk({tag, "_valid"}, 16'(rand_valid), 16'd0);
    chk({tag, "_busy"},  16'(busy), 16'(b));
  endtask

  task automatic do_reset();
    req       = '0;
    seed_load = 1'b0;
    seed_val  = '0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    seq_exp = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};
    rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat  = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};

    // Reset state
    rst = 1'b0; req = '0; seed_load = 1'b0; seed_val = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset", 1'b0);
    chk("reset_data", 16'(rand_data), 16'b1001);
    #1 rst = 1'b1;

    // Lone requester, dropped after its grant
    req = 4'b0100;
    tick(); chk_grant("t1_first", 4'b0100, 4'b1001);
    req = '0;
    tick(); chk_quiet("t1_idle", 1'b0);
    req = 4'b0100;
    tick(); chk_grant("t1_second", 4'b0100, 4'b0011);
    req = '0;
    tick();

    // All requesters held: back-to-back round-robin grants
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_grant($sformatf("t2_rr%0d", i), rr_gnt[i], rr_dat[i]);
    end
    req = '0;
    tick(); chk_quiet("t2_idle", 1'b0);

    // Single requester held: grant every other cycle, full LFSR period
    do_reset();
    req  = 4'b0001;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      tick(); chk_grant($sformatf("t3_g%0d", i), 4'b0001, seq_exp[i]);
      if (i < 15) seen[rand_data] = 1'b1;
      tick(); chk("t3_mask", 16'(gnt), 16'd0);
    end
    chk("t3_cover", seen, 16'hFFFE);
    req = '0;

    // Reseed; a second seed_load during SEED is ignored
    seed_load = 1'b1; seed_val = 4'b0110;
    tick(); chk_quiet("t4_seed", 1'b1);
    seed_val = 4'b1111; req = 4'b0010;
    tick(); chk_grant("t4_after", 4'b0010, 4'b0110);
    seed_load = 1'b0; req = '0;
    tick(); chk_quiet("t4_idle", 1'b0);

    // Zero seed replaced by default seed
    seed_load = 1'b1; seed_val = 4'b0000;
    tick(); chk_quiet("t4z_seed", 1'b1);
    seed_load = 1'b0; req = 4'b0010;
    tick(); chk_grant("t4z_after", 4'b0010, 4'b1001);
    req = '0;
    tick();

    // seed_load and req together: reseed wins first
    seed_load = 1'b1; seed_val = 4'b1101; req = 4'b0001;
    tick(); chk_quiet("t5_seed", 1'b1);
    seed_load = 1'b0;
    tick(); chk_grant("t5_after", 4'b0001, 4'b1101);
    req = '0;
    tick();

    // seed_load during a grant: grant completes, then SEED
    req = 4'b0100;
    tick(); chk_grant("t6_grant", 4'b0100, 4'b1010);
    req = '0; seed_load = 1'b1; seed_val = 4'b0101;
    tick(); chk_quiet("t6_seed", 1'b1);
    seed_load = 1'b0; req = 4'b1000;
    tick(); chk_grant("t6_after", 4'b1000, 4'b0101);
    req = '0;
    tick();

    // Asynchronous reset in the middle of a grant
    req = 4'b0100;
    tick(); chk_grant("t7_grant", 4'b0100, 4'b1011);
    req = 4'b0011;
    #2 rst = 1'b0;
    #1;
    chk_quiet("t7_rst", 1'b0);
    chk("t7_rst_data", 16'(rand_data), 16'b1001);
    #2 rst = 1'b1;
    tick(); chk_grant("t7_first", 4'b0001, 4'b1001);
    tick(); chk_grant("t7_second", 4'b0010, 4'b0011);
    req = '0;
    tick(); chk_quiet("t7_idle", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin controller sharing one 4-bit pseudorandom number generator (LFSR) among several requesters. Each grant hands exactly one fresh value to exactly one requester and steps the LFSR, so no two consumers ever see the same sample. The block also sequences reseeding. It sits between the PRNG datapath and its client blocks, for example game or test-pattern logic.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: LFSR/output width. Only 4 is supported, because the tap set is fixed.
- SEED, 4'b1001: LFSR value after reset, and the substitute for an all-zero seed.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high until its gnt bit is seen.
- seed_load  in  1  one-cycle pulse requesting a reseed.
- seed_val  in  WIDTH  seed sampled when seed_load is high.
- gnt  out  NREQ  one-hot grant, high for exactly one cycle per grant.
- rand_data  out  WIDTH  current LFSR state; meaningful only while rand_valid is high.
- rand_valid  out  1  high exactly when any gnt bit is high.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- LFSR step: next = {q[2:0], q[3]^q[2]} (x^4+x^3+1), period 15, never reaches 0000.
- FSM states:
  - IDLE: gnt = 0.
  - GRANT: one-hot gnt registered, rand_valid = 1.
  - SEED: one cycle, gnt = 0, LFSR loaded.
- Transitions, evaluated identically from IDLE and GRANT:
  - seed_load = 1 → SEED. Reseed has priority over requests.
  - else any eligible req → GRANT, with a new winner.
  - else → IDLE.
- From SEED: same rule, excluding seed_load.
- Eligible req: req[i] high and gnt[i] not high in the current cycle. This masks the winner's still-high req for one cycle.
- Round-robin arbitration:
  - Pointer holds the last winner index; search starts at pointer+1 mod NREQ.
  - Pointer updates only when a winner is registered.
  - Pointer resets to NREQ-1, so req[0] has top priority first.
- On every GRANT cycle the LFSR steps at the closing edge. rand_data during the grant is the pre-step value.
- Seed load: LFSR ← seed_val, or SEED if seed_val == 0. A seed_load during a GRANT cycle lets that grant complete, then SEED follows.
- seed_load while in SEED: ignored.

## Timing
- Reset values (asynchronous, immediate on rst low):
  - state = IDLE
  - gnt = 0, rand_valid = 0, busy = 0
  - LFSR = SEED, so rand_data = SEED
  - pointer = NREQ-1
- Grant latency: req high at edge k (from IDLE) → gnt high in the cycle after edge k.
- Throughput: one grant per cycle when different requesters are pending. A lone requester holding req continuously is granted every other cycle.
- Reseed costs exactly one cycle of no grants. The first grant after SEED returns the new seed.
- rst asserted mid-GRANT: gnt drops at once. Any in-flight grant is lost, and the requester keeps req high and is re-served.

## Structure
- Package prng_pkg holds:
  - WIDTH and SEED constants
  - the FSM state encoding (IDLE, GRANT, SEED)
  - the function lfsr_next(q)
- Sub-module prng_lfsr (clk, rst, load, load_val, step, q) holds the LFSR register. prng_arbiter holds the FSM, pointer, and one-hot encoder.

## Test plan
- Reset, then req = 0100 held → gnt = 0100 for one cycle with rand_data = 1001. Requester drops req; the next grant carries 0011.
- req = 1111 held for 5 cycles → gnt sequence 0001, 0010, 0100, 1000, 0001 with data 1001, 0011, 0110, 1101, 1010.
- Single requester re-asserting for 16 grants → values 1–15 each appear exactly once, 0000 never appears, and the 16th value equals 1001.
- seed_load with seed_val = 0110, then req = 0010 → busy high one cycle, then gnt = 0010 with rand_data = 0110. Repeat with seed_val = 0000 → rand_data = 1001.
- seed_load and req = 0001 in the same IDLE cycle → SEED first, then gnt = 0001 one cycle later with the new seed value.
- rst low during a GRANT cycle → gnt, rand_valid and busy go to 0 immediately. After release, req = 0011 → gnt = 0001 first with data 1001.
